lsq_mem_controller: RTL and testbench

Sequencer between the load/store queue and the data-cache port. Takes the LSQ head entry, decides when it may issue, pops it, drives one aligned data-memory request with byte masks, and broadcasts load results and store completions on the CDB. Stores issue only when they are the ROB head, and at most one memory operation is outstanding. Sits between `load_store_queue`, the ROB and the D-cache arbiter.

---
 rtl/rv32i_types.sv | 45 ++++
 rtl/lsq_mem_controller_load_align.sv | 45 ++++
 rtl/lsq_mem_controller.sv | 176 +++++++++++++++++
 tb/tb_lsq_mem_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the LSQ-to-D-cache sequencer: LSQ entry layout, sequencer
// state encoding, funct3 load/store encodings and base byte masks.
package rv32i_types;

  localparam int ROB_IDX_BITS  = 5;
  localparam int PHYS_REG_BITS = 6;

  typedef struct packed {
    logic                     is_store;
    logic [2:0]               funct3;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [ROB_IDX_BITS-1:0]  rob_idx;
    logic [PHYS_REG_BITS-1:0] pd;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lsq_ctrl_state_t;

  // funct3 encodings shared by loads and stores (SB/SH/SW reuse B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane masks before shifting into position by the address offset
  localparam logic [3:0] LB_MASK = 4'b0001;
  localparam logic [3:0] LH_MASK = 4'b0011;
  localparam logic [3:0] LW_MASK = 4'b1111;

  // Halfwords need an even address, words a 4-byte-aligned one
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsq_mem_controller_load_align.sv
// load_align: byte-lane placement for the data-cache port. Produces the
// byte mask and lane-shifted store data for a request, and realigns plus
// sign/zero-extends returned load data. Purely combinational.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_shifted_o,
  output logic [31:0] rdata_ext_o
);

  logic [4:0]  shamt;
  logic [31:0] rdata_sh;

  assign shamt           = {offset_i, 3'b000};
  assign wdata_shifted_o = wdata_i << shamt;
  assign rdata_sh        = rdata_i >> shamt;

  // Byte mask by access size; bits pushed past lane 3 are simply dropped
  always_comb begin
    mask_o = LW_MASK;
    case (funct3_i[1:0])
      2'b00:   mask_o = LB_MASK << offset_i;
      2'b01:   mask_o = LH_MASK << offset_i;
      default: mask_o = LW_MASK;
    endcase
  end

  // Extend the realigned load data according to the load type
  always_comb begin
    rdata_ext_o = rdata_sh;
    case (funct3_i)
      F3_B:    rdata_ext_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_H:    rdata_ext_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_BU:   rdata_ext_o = {24'd0, rdata_sh[7:0]};
      F3_HU:   rdata_ext_o = {16'd0, rdata_sh[15:0]};
      default: rdata_ext_o = rdata_sh;
    endcase
  end

endmodule

// File: rtl/lsq_mem_controller.sv
// lsq_mem_controller: issues the LSQ head to the data-cache port one
// operation at a time and broadcasts the result on the CDB.
// Handshake: lsq_pop pulses in the cycle the head is accepted; a request is
// live while dmem_rmask/dmem_wmask is nonzero and is held unchanged until the
// cycle dmem_resp is sampled high; cdb_valid is a single-cycle strobe.
// Optional build macro LSQ_CTRL_MISALIGN_CHECK_EN adds misalignment trapping
// and the cdb_exc output.
module lsq_mem_controller #(
  parameter int ROB_IDX_BITS = rv32i_types::ROB_IDX_BITS,
  parameter int PREG_BITS    = rv32i_types::PHYS_REG_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mispredict,
  input  logic                    lsq_empty,
  input  rv32i_types::lsq_entry_t lsq_head,
  output logic                    lsq_pop,
  input  logic                    rob_head_valid,
  input  logic [ROB_IDX_BITS-1:0] rob_head_idx,
  output logic [31:0]             dmem_addr,
  output logic [3:0]              dmem_rmask,
  output logic [3:0]              dmem_wmask,
  output logic [31:0]             dmem_wdata,
  input  logic [31:0]             dmem_rdata,
  input  logic                    dmem_resp,
  output logic                    cdb_valid,
  output logic [ROB_IDX_BITS-1:0] cdb_rob_idx,
  output logic [PREG_BITS-1:0]    cdb_pd,
  output logic [31:0]             cdb_data
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
  ,
  output logic                    cdb_exc
`endif
);

  import rv32i_types::*;

  lsq_ctrl_state_t         state_q;
  logic                    is_store_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic [ROB_IDX_BITS-1:0] rob_q;
  logic [PREG_BITS-1:0]    pd_q;

  logic [31:0]             dmem_addr_q, dmem_wdata_q, cdb_data_q;
  logic [3:0]              dmem_rmask_q, dmem_wmask_q;
  logic                    cdb_valid_q;
  logic [ROB_IDX_BITS-1:0] cdb_rob_idx_q;
  logic [PREG_BITS-1:0]    cdb_pd_q;

  logic                    head_is_rob_head, issue, skip_req;
  logic [2:0]              align_funct3;
  logic [1:0]              align_off;
  logic [3:0]              align_mask;
  logic [31:0]             align_wdata, align_rdata;

  assign head_is_rob_head = rob_head_valid && (rob_head_idx == lsq_head.rob_idx);
  assign issue = (state_q == ST_IDLE) && !lsq_empty && !mispredict &&
                 (!lsq_head.is_store || head_is_rob_head);
  assign lsq_pop = issue;

`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
  logic cdb_exc_q;
  assign skip_req = is_misaligned(lsq_head.funct3, lsq_head.addr[1:0]);
  assign cdb_exc  = cdb_exc_q;
`else
  assign skip_req = 1'b0;
`endif

  // The aligner formats the head while idle and the latched entry afterwards
  assign align_funct3 = (state_q == ST_IDLE) ? lsq_head.funct3     : funct3_q;
  assign align_off    = (state_q == ST_IDLE) ? lsq_head.addr[1:0] : off_q;

  load_align u_align (
    .funct3_i        (align_funct3),
    .offset_i        (align_off),
    .wdata_i         (lsq_head.wdata),
    .rdata_i         (dmem_rdata),
    .mask_o          (align_mask),
    .wdata_shifted_o (align_wdata),
    .rdata_ext_o     (align_rdata)
  );

  // Sequencer FSM with registered memory-request and broadcast outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      rob_q         <= '0;
      pd_q          <= '0;
      dmem_addr_q   <= 32'd0;
      dmem_wdata_q  <= 32'd0;
      dmem_rmask_q  <= 4'd0;
      dmem_wmask_q  <= 4'd0;
      cdb_valid_q   <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_pd_q      <= '0;
      cdb_data_q    <= 32'd0;
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
      cdb_exc_q     <= 1'b0;
`endif
    end else begin
      cdb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            is_store_q <= lsq_head.is_store;
            funct3_q   <= lsq_head.funct3;
            off_q      <= lsq_head.addr[1:0];
            rob_q      <= lsq_head.rob_idx;
            pd_q       <= lsq_head.pd;
            if (skip_req) begin
              // Trapped access: no memory traffic, report the faulting address
              cdb_valid_q   <= 1'b1;
              cdb_data_q    <= lsq_head.addr;
              cdb_rob_idx_q <= lsq_head.rob_idx;
              cdb_pd_q      <= lsq_head.pd;
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
              cdb_exc_q     <= 1'b1;
`endif
              state_q       <= ST_DONE;
            end else begin
              dmem_addr_q  <= {lsq_head.addr[31:2], 2'b00};
              dmem_wdata_q <= align_wdata;
              dmem_rmask_q <= lsq_head.is_store ? 4'd0 : align_mask;
              dmem_wmask_q <= lsq_head.is_store ? align_mask : 4'd0;
              state_q      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_resp) begin
            dmem_rmask_q <= 4'd0;
            dmem_wmask_q <= 4'd0;
            if (mispredict) begin
              state_q <= ST_IDLE;
            end else begin
              cdb_valid_q   <= 1'b1;
              cdb_data_q    <= is_store_q ? 32'd0 : align_rdata;
              cdb_rob_idx_q <= rob_q;
              cdb_pd_q      <= pd_q;
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
              cdb_exc_q     <= 1'b0;
`endif
              state_q       <= ST_DONE;
            end
          end else if (mispredict) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The request stays on the port until memory answers; result dropped
          if (dmem_resp) begin
            dmem_rmask_q <= 4'd0;
            dmem_wmask_q <= 4'd0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_rmask  = dmem_rmask_q;
  assign dmem_wmask  = dmem_wmask_q;
  // A squash arriving in the broadcast cycle kills the broadcast
  assign cdb_valid   = cdb_valid_q && !mispredict;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_pd      = cdb_pd_q;
  assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_lsq_mem_controller.sv
// Testbench for lsq_mem_controller. Directed scenarios followed by random
// transactions, checked against a byte-level reference model. Honours the
// LSQ_CTRL_MISALIGN_CHECK_EN macro when it is defined for the build.
module tb_lsq_mem_controller;
  import rv32i_types::*;

  localparam int RB = ROB_IDX_BITS;
  localparam int PB = PHYS_REG_BITS;

  logic          clk = 1'b0;
  logic          rst, mispredict, lsq_empty, lsq_pop;
  lsq_entry_t    lsq_head;
  logic          rob_head_valid;
  logic [RB-1:0] rob_head_idx;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata, cdb_data;
  logic [3:0]    dmem_rmask, dmem_wmask;
  logic          dmem_resp, cdb_valid;
  logic [RB-1:0] cdb_rob_idx;
  logic [PB-1:0] cdb_pd;
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
  logic          cdb_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  lsq_mem_controller dut (
    .clk            (clk),
    .rst            (rst),
    .mispredict     (mispredict),
    .lsq_empty      (lsq_empty),
    .lsq_head       (lsq_head),
    .lsq_pop        (lsq_pop),
    .rob_head_valid (rob_head_valid),
    .rob_head_idx   (rob_head_idx),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .cdb_pd         (cdb_pd),
    .cdb_data       (cdb_data)
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
    ,
    .cdb_exc        (cdb_exc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    int lane;
    if (m_size(f3) == 4) return 4'hF;
    m = 4'h0;
    for (int b = 0; b < m_size(f3); b++) begin
      lane = int'(off) + b;
      if (lane < 4) m[lane] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] off);
    logic [31:0] r;
    r = 32'd0;
    for (int l = 0; l < 4; l++)
      if (l >= int'(off)) r[8*l +: 8] = wd[8*(l-int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] r;
    int lane, sz;
    sz = m_size(f3);
    r  = 32'd0;
    for (int b = 0; b < sz; b++) begin
      lane = int'(off) + b;
      if (lane < 4) r[8*b +: 8] = rd[8*lane +: 8];
    end
    if (sz < 4 && !f3[2] && r[8*sz-1])
      for (int i = 8*sz; i < 32; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [1:0] off);
    if (m_size(f3) == 2) return off[0];
    if (m_size(f3) == 4) return off != 2'd0;
    return 1'b0;
  endfunction

  function automatic lsq_entry_t mk(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input int rob, input int pd);
    lsq_entry_t e;
    e.is_store = st;
    e.funct3   = f3;
    e.addr     = a;
    e.wdata    = wd;
    e.rob_idx  = RB'(rob);
    e.pd       = PB'(pd);
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the DUT idle; returns at a falling edge
  // with the DUT idle again. mp_cyc selects a REQ cycle (0..lat) for a
  // mispredict pulse, -1 for none; mp_done squashes in the broadcast cycle.
  task automatic txn(input lsq_entry_t e, input int gate, input int lat, input int mp_cyc,
                     input bit mp_done, input logic [31:0] rd, input string tag);
    logic [1:0]  off;
    logic [31:0] exp_d;
    bit          exc_path, bcast;
    off = e.addr[1:0];
    lsq_empty = 1'b0;
    lsq_head  = e;
    rob_head_valid = 1'b1;
    for (int g = 0; g < gate; g++) begin
      rob_head_idx = e.rob_idx - RB'(1);
      #1 check({tag, " gated_pop"}, 32'(lsq_pop), 32'd0);
      @(negedge clk);
    end
    rob_head_idx = e.is_store ? e.rob_idx : e.rob_idx + RB'(2);
    #1 check({tag, " pop"}, 32'(lsq_pop), 32'd1);
    @(negedge clk);
    lsq_empty = 1'b1;
    exc_path = 1'b0;
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
    exc_path = m_misal(e.funct3, off);
`endif
    if (exc_path) begin
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
      check({tag, " exc"}, 32'(cdb_exc), 32'd1);
`endif
      check({tag, " exc_valid"}, 32'(cdb_valid), 32'd1);
      check({tag, " exc_data"}, cdb_data, e.addr);
      check({tag, " exc_tag"}, 32'(cdb_rob_idx), 32'(e.rob_idx));
      check({tag, " exc_masks"}, {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
      @(negedge clk);
      check({tag, " exc_valid_end"}, 32'(cdb_valid), 32'd0);
      check({tag, " exc_masks_end"}, {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      check({tag, " addr"}, dmem_addr, {e.addr[31:2], 2'b00});
      check({tag, " rmask"}, 32'(dmem_rmask), e.is_store ? 32'd0 : 32'(m_mask(e.funct3, off)));
      check({tag, " wmask"}, 32'(dmem_wmask), e.is_store ? 32'(m_mask(e.funct3, off)) : 32'd0);
      check({tag, " wdata"}, dmem_wdata, m_wdata(e.wdata, off));
      check({tag, " early_cdb"}, 32'(cdb_valid), 32'd0);
      dmem_resp  = (k == lat);
      dmem_rdata = (k == lat) ? rd : $urandom;
      mispredict = (k == mp_cyc);
      @(negedge clk);
      dmem_resp  = 1'b0;
      mispredict = 1'b0;
    end
    bcast = !(mp_cyc >= 0 && mp_cyc <= lat);
    check({tag, " masks_after"}, {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    if (bcast) begin
      exp_d = e.is_store ? 32'd0 : m_load(e.funct3, off, rd);
      if (!mp_done) exp_q.push_back(exp_d);
      lsq_empty  = 1'b0;
      lsq_head   = mk(1'b0, F3_W, $urandom, $urandom, 1, 1);
      mispredict = mp_done;
      #1 check({tag, " pop_in_done"}, 32'(lsq_pop), 32'd0);
      check({tag, " cdb_valid"}, 32'(cdb_valid), mp_done ? 32'd0 : 32'd1);
      if (!mp_done) begin
        check({tag, " cdb_data"}, cdb_data, exp_q.pop_front());
        check({tag, " cdb_tag"}, 32'(cdb_rob_idx), 32'(e.rob_idx));
        check({tag, " cdb_pd"}, 32'(cdb_pd), 32'(e.pd));
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
        check({tag, " cdb_exc"}, 32'(cdb_exc), 32'd0);
`endif
      end
      @(negedge clk);
      mispredict = 1'b0;
      lsq_empty  = 1'b1;
      check({tag, " cdb_one_cycle"}, 32'(cdb_valid), 32'd0);
    end else begin
      check({tag, " squashed_cdb"}, 32'(cdb_valid), 32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    lsq_entry_t  e;
    bit          st;
    logic [2:0]  f3;
    int          lat, mpc;
    logic [2:0]  ld_ops[5];
    ld_ops = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    rst = 1'b0; mispredict = 1'b0; lsq_empty = 1'b1; rob_head_valid = 1'b0;
    rob_head_idx = '0; dmem_rdata = 32'd0; dmem_resp = 1'b0;
    lsq_head = mk(1'b0, F3_W, 32'd0, 32'd0, 0, 0);
    @(negedge clk); @(negedge clk);
    check("reset pop", 32'(lsq_pop), 32'd0);
    check("reset cdb_valid", 32'(cdb_valid), 32'd0);
    check("reset masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("reset addr", dmem_addr, 32'd0);
    check("reset wdata", dmem_wdata, 32'd0);
    check("reset cdb_data", cdb_data, 32'd0);
    check("reset cdb_tags", {16'd0, 8'(cdb_rob_idx), 8'(cdb_pd)}, 32'd0);
`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
    check("reset cdb_exc", 32'(cdb_exc), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    txn(mk(1'b0, F3_W, 32'h100, 32'h0, 3, 10), 0, 3, -1, 1'b0, 32'hDEADBEEF, "lw");
    txn(mk(1'b0, F3_B, 32'h103, 32'h0, 4, 11), 0, 1, -1, 1'b0, 32'h80123456, "lb");
    txn(mk(1'b0, F3_BU, 32'h103, 32'h0, 6, 12), 0, 0, -1, 1'b0, 32'h80123456, "lbu");
    txn(mk(1'b1, F3_H, 32'h202, 32'h1234, 5, 0), 3, 2, -1, 1'b0, 32'h0, "sh_gate");
    txn(mk(1'b0, F3_W, 32'h140, 32'h0, 7, 13), 0, 2, 0, 1'b0, 32'h11111111, "lw_drain");
    txn(mk(1'b0, F3_HU, 32'h146, 32'h0, 8, 14), 0, 1, -1, 1'b0, 32'hBEEF0000, "next_after_drain");
    txn(mk(1'b0, F3_H, 32'h150, 32'h0, 9, 15), 0, 1, 1, 1'b0, 32'h00008000, "mp_and_resp");
    txn(mk(1'b0, F3_H, 32'h152, 32'h0, 10, 16), 0, 1, -1, 1'b1, 32'h80000000, "mp_in_done");

    // mispredict while idle blocks issue
    lsq_empty = 1'b0;
    lsq_head  = mk(1'b0, F3_W, 32'h180, 32'h0, 11, 17);
    mispredict = 1'b1;
    #1 check("idle_mp pop", 32'(lsq_pop), 32'd0);
    @(negedge clk);
    mispredict = 1'b0;
    lsq_empty  = 1'b1;
    // stray response while idle is ignored
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("idle_resp cdb_valid", 32'(cdb_valid), 32'd0);
    check("idle_resp masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);

    // reset in the middle of a request
    lsq_empty = 1'b0;
    lsq_head  = mk(1'b0, F3_W, 32'h300, 32'h0, 12, 18);
    #1 check("rst_mid pop", 32'(lsq_pop), 32'd1);
    @(negedge clk);
    lsq_empty = 1'b1;
    check("rst_mid rmask_before", 32'(dmem_rmask), 32'hF);
    rst = 1'b0;
    #1 check("rst_mid masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("rst_mid addr", dmem_addr, 32'd0);
    check("rst_mid cdb_valid", 32'(cdb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef LSQ_CTRL_MISALIGN_CHECK_EN
    txn(mk(1'b0, F3_W, 32'h101, 32'h0, 13, 19), 0, 1, -1, 1'b0, 32'h0, "misaligned_lw");
`endif

    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
      lat = $urandom_range(0, 3);
      mpc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
      e   = mk(st, f3, $urandom, $urandom, $urandom_range(0, 31), $urandom_range(0, 63));
      txn(e, st ? $urandom_range(0, 2) : 0, lat, mpc, ($urandom_range(0, 7) == 0),
          $urandom, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
